led_pwm_ctrl_n: RTL and testbench
=================================

LED_PWM_CTRL_N -- requirements
Module: led_pwm_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of LED channels; legal values are multiples of 4 in the range 4..32.
REQ-002 SHALL have parameter PRESCALE, default 1: clk cycles per PWM count step; legal values are 1..65535.
REQ-003 SHALL have localparam ADDR_BITS = $clog2(NUM_CH+3+NUM_CH/4).
REQ-004 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port addr, input, ADDR_BITS: register index.
REQ-007 SHALL have port w_en, input, 1: write strobe, one cycle per write.
REQ-008 SHALL have port wdata, input, 8: write data.
REQ-009 SHALL have port rdata, output, 8: combinational read of the register at addr.
REQ-010 SHALL have port leds, output, NUM_CH: LED drive, bit i is channel i.
REQ-011 SHALL have port pwm_wrap, output, 1: one-cycle pulse on each PWM period wrap.

Function
REQ-012 SHALL use this register map: 0 MODE; 1..NUM_CH PWM0..PWM(NUM_CH-1); NUM_CH+1 GRPPWM; NUM_CH+2 GRPFREQ; NUM_CH+3.. LEDOUT0..LEDOUT(NUM_CH/4-1).
REQ-013 SHALL use MODE bit4 as SLEEP, bit3 as DMBLNK and bit2 as INVRT; all other MODE bits are stored and read back but have no effect.
REQ-014 SHALL update the addressed register with wdata on the clk edge where w_en=1; writes to unmapped addresses are ignored; unmapped reads return 8'h00.
REQ-015 SHALL return on rdata the value held in the register file at addr, including values written on the previous edge; rdata never returns shadow (active) values.
REQ-016 SHALL generate a tick every PRESCALE clk cycles; pwm_cnt (8 bits) increments per tick and wraps from 255 to 0.
REQ-017 SHALL assert pwm_wrap for exactly one clk cycle, on the cycle in which pwm_cnt wraps from 255 to 0.
REQ-018 SHALL keep per-channel active duty registers, loaded from PWMx only when pwm_wrap=1 (glitch-free update).
REQ-019 SHALL load the pre-write PWMx value into the active duty when a PWMx write coincides with pwm_wrap; the new value becomes active at the next wrap.
REQ-020 SHALL compute individual PWM as ind_i = (pwm_cnt < active_duty_i): duty 0 is always off; duty 255 is on for 255 of 256 counts.
REQ-021 SHALL run a group sub-counter over PWM periods: in dimming mode (DMBLNK=0) phase (8 bits) advances every pwm_wrap; in blink mode (DMBLNK=1) phase advances every (GRPFREQ+1) wraps. The sub-counter counts 0..GRPFREQ and clears when phase steps.
REQ-022 SHALL compute the group gate grp = (phase < GRPPWM), giving a blink period of 256*(GRPFREQ+1) PWM periods.
REQ-023 SHALL clear the sub-counter on any GRPFREQ write or any DMBLNK change, so no stale count exceeds the new limit.
REQ-024 SHALL decode LEDOUT bits [2k+1:2k] for channel 4j+k from LEDOUTj: 00 off; 01 full on; 10 ind_i; 11 ind_i AND grp.
REQ-025 SHALL force every channel's on value to 0 while SLEEP=1, and hold pwm_cnt, the prescaler, the sub-counter and phase at 0; the first tick occurs PRESCALE cycles after SLEEP clears.
REQ-026 SHALL drive leds[i] = on_i XOR INVRT, registered, so leds has one cycle of latency from internal state.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear all registers, active duties, all counters and phase to 0, with leds=0 and pwm_wrap=0.
REQ-028 SHALL abort any period in progress on reset assertion mid-operation, and restart counting from 0 on the first edge after release.

Verification
REQ-029 SHALL verify the full-on case: after reset, write LEDOUT0=8'h55 -> leds[3:0]=4'hF one cycle after the write while PWM continues; rdata at LEDOUT0 reads 8'h55.
REQ-030 SHALL verify individual PWM: LEDOUT0=8'hAA, PWM0=8'h40, PRESCALE=1 -> after the next pwm_wrap, leds[0] is high exactly 64 of every 256 cycles; a PWM0=8'hC0 write mid-period does not change the count until the following wrap.
REQ-031 SHALL verify the wrap collision: a PWM1 write coincident with pwm_wrap -> the old duty is used for one more period, then the new duty applies.
REQ-032 SHALL verify group blink: LEDOUT0=8'hFF, PWM0..3=8'hFF, MODE=8'h08, GRPFREQ=8'h01, GRPPWM=8'h80 -> the gate is high for 256 PWM periods and low for 256, with a total period of 512 periods.
REQ-033 SHALL verify sleep and invert: with MODE=8'h14 -> leds=all 1s, counters held at 0; with MODE=8'h00 -> normal PWM resumes from pwm_cnt=0.
REQ-034 SHALL verify reset mid-blink: pulse reset_n low -> leds=0 immediately, all registers read 8'h00, and pwm_wrap is first seen 256*PRESCALE cycles after release.

Source files
------------

// File: rtl/led_pwm_ctrl_n.sv
// led_pwm_ctrl_n: register-programmed multi-channel LED PWM driver with group dim/blink, sleep and invert.
module led_pwm_ctrl_n #(
  parameter int NUM_CH = 8,
  parameter int PRESCALE = 1,
  localparam int ADDR_BITS = $clog2(NUM_CH + 3 + NUM_CH / 4)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 w_en,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic [NUM_CH-1:0]    leds,
  output logic                 pwm_wrap
);
  localparam int NG = NUM_CH / 4;
  localparam int A_GRPPWM = NUM_CH + 1;
  localparam int A_GRPFREQ = NUM_CH + 2;
  localparam int A_LED = NUM_CH + 3;
  logic [7:0] mode_q, grppwm_q, grpfreq_q;
  logic [7:0] pwm_q [NUM_CH];
  logic [7:0] duty_q [NUM_CH];
  logic [7:0] ledout_q [NG];
  logic [15:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d, sub_q, sub_d, phase_q, phase_d;
  logic wrap_q, wrap_d, tick, step, sub_clr, grp;
  logic [NUM_CH-1:0] on, leds_q;
  int a;
  wire sleep = mode_q[4];
  wire dmblnk = mode_q[3];
  wire invrt = mode_q[2];
  assign a = int'(addr);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode_q <= '0;
      grppwm_q <= '0;
      grpfreq_q <= '0;
      for (int i = 0; i < NUM_CH; i++) pwm_q[i] <= '0;
      for (int i = 0; i < NG; i++) ledout_q[i] <= '0;
    end else if (w_en) begin
      if (a == 0) mode_q <= wdata;
      if (a == A_GRPPWM) grppwm_q <= wdata;
      if (a == A_GRPFREQ) grpfreq_q <= wdata;
      for (int i = 0; i < NUM_CH; i++) if (a == i + 1) pwm_q[i] <= wdata;
      for (int i = 0; i < NG; i++) if (a == A_LED + i) ledout_q[i] <= wdata;
    end
  always_comb begin
    rdata = '0;
    if (a == 0) rdata = mode_q;
    if (a == A_GRPPWM) rdata = grppwm_q;
    if (a == A_GRPFREQ) rdata = grpfreq_q;
    for (int i = 0; i < NUM_CH; i++) if (a == i + 1) rdata = pwm_q[i];
    for (int i = 0; i < NG; i++) if (a == A_LED + i) rdata = ledout_q[i];
  end
  // Sub-counter restarts whenever its limit or meaning changes, so it never overshoots.
  assign sub_clr = w_en && (a == A_GRPFREQ || (a == 0 && wdata[3] != dmblnk));
  always_comb begin
    tick = pre_q == 16'(PRESCALE - 1);
    pre_d = (sleep || tick) ? '0 : pre_q + 16'd1;
    cnt_d = sleep ? '0 : cnt_q + {7'd0, tick};
    wrap_d = !sleep && tick && cnt_q == 8'hFF;
    step = wrap_q && (!dmblnk || sub_q >= grpfreq_q);
    sub_d = (sleep || step || sub_clr) ? '0 : sub_q + {7'd0, wrap_q};
    phase_d = sleep ? '0 : phase_q + {7'd0, step};
  end
  assign grp = phase_q < grppwm_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0] sel;
    logic ind;
    assign sel = ledout_q[g/4][2*(g%4) +: 2];
    assign ind = cnt_q < duty_q[g];
    assign on[g] = !sleep && (sel == 2'd1 || (sel[1] && ind && (!sel[0] || grp)));
  end
  // Active duties only change at a period wrap, so a PWMx write never glitches a period.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      wrap_q <= 1'b0;
      sub_q <= '0;
      phase_q <= '0;
      leds_q <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
      sub_q <= sub_d;
      phase_q <= phase_d;
      leds_q <= on ^ {NUM_CH{invrt}};
      if (wrap_q) for (int i = 0; i < NUM_CH; i++) duty_q[i] <= pwm_q[i];
    end
  assign leds = leds_q;
  assign pwm_wrap = wrap_q;
endmodule

// File: tb/tb_led_pwm_ctrl_n.sv
// tb_led_pwm_ctrl_n: directed self-checking bench for led_pwm_ctrl_n (NUM_CH=8, PRESCALE=1).
module tb_led_pwm_ctrl_n;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] addr;
  logic w_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] leds;
  logic pwm_wrap;
  int checks = 0;
  int fails = 0;
  int cnts [8];
  typedef struct { logic [3:0] a; logic [7:0] d; logic [7:0] e; } vec_t;
  vec_t vt [10];

  led_pwm_ctrl_n #(.NUM_CH(8), .PRESCALE(1)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .w_en(w_en), .wdata(wdata),
    .rdata(rdata), .leds(leds), .pwm_wrap(pwm_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a;
    wdata = d;
    w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_wrap();
    int n = 0;
    while (!pwm_wrap && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!pwm_wrap) begin
      checks++;
      fails++;
      $display("FAIL wait_wrap: no pwm_wrap within %0d cycles", n);
    end
  endtask

  task automatic cyc_to_wrap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_wrap && n < 1000);
  endtask

  task automatic count_periods(input int ch, input int np, input int mp, input logic [3:0] ma, input logic [7:0] md);
    for (int p = 0; p < np; p++) begin
      cnts[p] = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        cnts[p] += leds[ch] ? 1 : 0;
        w_en = 1'b0;
        if (p == mp && i == 128) begin
          addr = ma;
          wdata = md;
          w_en = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int n, w, bad;
    vt[0] = '{4'd0,  8'hE3, 8'hE3};
    vt[1] = '{4'd1,  8'h11, 8'h11};
    vt[2] = '{4'd4,  8'h44, 8'h44};
    vt[3] = '{4'd8,  8'h88, 8'h88};
    vt[4] = '{4'd9,  8'h5A, 8'h5A};
    vt[5] = '{4'd10, 8'hA5, 8'hA5};
    vt[6] = '{4'd11, 8'h3C, 8'h3C};
    vt[7] = '{4'd12, 8'hC3, 8'hC3};
    vt[8] = '{4'd13, 8'h77, 8'h00};
    vt[9] = '{4'd15, 8'hFF, 8'h00};
    reset_n = 1'b1;
    w_en = 1'b0;
    addr = '0;
    wdata = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_leds", int'(leds), 0);
    chk("reset_wrap", int'(pwm_wrap), 0);
    chk("reset_mode", int'(rdata), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      wr(vt[i].a, vt[i].d);
      #1 chk($sformatf("reg_wr_a%0d", vt[i].a), int'(rdata), int'(vt[i].e));
    end
    for (int i = 0; i < 10; i++) begin
      addr = vt[i].a;
      #1 chk($sformatf("reg_rd_a%0d", vt[i].a), int'(rdata), int'(vt[i].e));
    end
    @(negedge clk);

    do_reset();
    wr(4'd11, 8'h55);
    chk("fullon_latency", int'(leds[3:0]), 0);
    @(negedge clk);
    chk("fullon_leds", int'(leds[3:0]), 15);
    addr = 4'd11;
    #1 chk("fullon_rdata", int'(rdata), 8'h55);
    @(negedge clk);

    do_reset();
    wr(4'd11, 8'hAA);
    wr(4'd1, 8'h40);
    wr(4'd2, 8'h20);
    wait_wrap();
    @(negedge clk);
    count_periods(0, 3, 1, 4'd1, 8'hC0);
    chk("ind_p0", cnts[0], 64);
    chk("ind_midwrite", cnts[1], 64);
    chk("ind_newduty", cnts[2], 192);
    wait_wrap();
    wr(4'd2, 8'hE0);
    count_periods(1, 2, -1, 4'd0, 8'h00);
    chk("collide_old", cnts[0], 32);
    chk("collide_new", cnts[1], 224);

    do_reset();
    wr(4'd11, 8'hFF);
    for (int i = 1; i <= 4; i++) wr(4'(i), 8'hFF);
    wr(4'd10, 8'h01);
    wr(4'd9, 8'h02);
    wr(4'd0, 8'h08);
    wait_wrap();
    @(negedge clk);
    count_periods(0, 6, -1, 4'd0, 8'h00);
    for (int p = 0; p < 6; p++) chk($sformatf("blink_p%0d", p + 1), cnts[p], p < 3 ? 255 : 0);

    wr(4'd11, 8'h55);
    @(negedge clk);
    chk("preRst_leds", int'(leds[3:0]), 15);
    reset_n = 1'b0;
    #1;
    chk("midRst_leds", int'(leds), 0);
    chk("midRst_wrap", int'(pwm_wrap), 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1 if (rdata != 8'h00) bad++;
    end
    chk("midRst_regs_nonzero", bad, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc_to_wrap(n);
    chk("midRst_first_wrap", n, 256);

    wr(4'd11, 8'h55);
    wr(4'd0, 8'h14);
    @(negedge clk);
    chk("sleep_inv_leds", int'(leds), 8'hFF);
    w = 0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_wrap) w++;
      if (leds != 8'hFF) bad++;
    end
    chk("sleep_wraps", w, 0);
    chk("sleep_leds_bad", bad, 0);
    wr(4'd0, 8'h00);
    cyc_to_wrap(n);
    chk("wake_first_wrap", n, 256);
    chk("wake_leds", int'(leds), 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
